// File: rtl/sram_1p_req_ctrl_if.sv
// Request/response handshake bundle between a client and sram_1p_req_ctrl.
// The master issues requests and consumes responses.
interface sram_1p_req_ctrl_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sram_1p_req_ctrl.sv
// Request-side controller for a 1-port SRAM macro: init sweep, then
// read/write requests with a credit-limited in-order response FIFO.
module sram_1p_req_ctrl #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    RESP_DEPTH = 2,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  sram_1p_req_ctrl_if.slave     bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_wmode,
  output logic [DATA_WIDTH-1:0] RW0_wdata,
  input  logic [DATA_WIDTH-1:0] RW0_rdata
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [PW-1:0]         head, tail;
  logic [DATA_WIDTH-1:0] fifo [RESP_DEPTH];
  logic                  ready, done_nx;
  logic                  credit, accept, rd_acc;
  logic                  push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (32'(p) == RESP_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Credit counts the read in the macro pipe as already occupying a slot.
  assign credit = (32'(count) + 32'(inflight)) < 32'(RESP_DEPTH);
  assign accept = bus.req_valid & ready;
  assign rd_acc = accept & ~bus.req_write;
  assign push   = inflight;
  assign pop    = (count != '0) & bus.resp_ready;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (count != '0);
  assign bus.resp_data  = fifo[head];

  always_comb begin
    state_nx  = state;
    done_nx   = init_done;
    ready     = 1'b0;
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    // Keep the macro idle while reset is held.
    if (!reset) begin
      unique case (state)
        S_INIT: begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = init_cnt;
          RW0_wdata = INIT_VALUE;
          if (init_cnt == '1) begin
            state_nx = S_RUN;
            done_nx  = 1'b1;
          end
        end
        S_RUN: begin
          done_nx = 1'b1;
          ready   = init_done & (bus.req_write | credit);
          if (bus.req_valid && ready) begin
            RW0_en    = 1'b1;
            RW0_wmode = bus.req_write;
            RW0_addr  = bus.req_addr;
            RW0_wdata = bus.req_write ? bus.req_wdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT_EN ? S_INIT : S_RUN;
      init_done <= 1'b0;
      init_cnt  <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) fifo[i] <= '0;
    end else begin
      state     <= state_nx;
      init_done <= done_nx;
      inflight  <= rd_acc;
      if (state == S_INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
      if (push) begin
        fifo[tail] <= RW0_rdata;
        tail       <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_1p_req_ctrl.sv
// Scoreboard bench for sram_1p_req_ctrl with a behavioural SRAM macro
// and an array-based reference of the memory contents.
module tb_sram_1p_req_ctrl;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int WORDS = 2 ** AW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_1p_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          init_done;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;

  sram_1p_req_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESP_DEPTH(DEPTH),
    .INIT_EN(1'b1),
    .INIT_VALUE(8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .init_done(init_done),
    .RW0_addr(RW0_addr),
    .RW0_en(RW0_en),
    .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata),
    .RW0_rdata(RW0_rdata)
  );

  logic [DW-1:0] sram [WORDS];
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) sram[RW0_addr] <= RW0_wdata;
      else RW0_rdata <= sram[RW0_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] model_mem [WORDS];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_resp;
  int resp_cnt = 0;
  bit running = 0;
  int rr_mode = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endfunction

  always @(posedge clock) begin
    #1;
    case (rr_mode)
      0:       bus.resp_ready = 1'b0;
      1:       bus.resp_ready = 1'b1;
      default: bus.resp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Outstanding reads = entries in exp_q; a read is acceptable below DEPTH.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else if (running) begin
      if (bus.req_valid)
        chk("req_ready", bus.req_ready,
            bus.req_write ? 1 : (exp_q.size() < DEPTH));
      if (bus.req_valid && bus.req_ready) begin
        chk("rw0_en", RW0_en, 1);
        chk("rw0_wmode", RW0_wmode, bus.req_write);
        chk("rw0_addr", RW0_addr, bus.req_addr);
        if (bus.req_write) begin
          chk("rw0_wdata", RW0_wdata, bus.req_wdata);
          model_mem[bus.req_addr] = bus.req_wdata;
        end else begin
          exp_q.push_back(model_mem[bus.req_addr]);
        end
      end else begin
        chk("rw0_idle", RW0_en, 0);
      end
      if (bus.resp_valid) chk("resp_pending", exp_q.size() != 0, 1);
      if (bus.resp_valid && bus.resp_ready && exp_q.size() != 0) begin
        chk("resp_data", bus.resp_data, exp_q.pop_front());
        last_resp = bus.resp_data;
        resp_cnt++;
      end
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_data"}, bus.resp_data, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_rw0_en"}, RW0_en, 0);
    chk({tag, "_rw0_wmode"}, RW0_wmode, 0);
    chk({tag, "_rw0_addr"}, RW0_addr, 0);
    chk({tag, "_rw0_wdata"}, RW0_wdata, 0);
  endtask

  task automatic init_check();
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clock);
      chk("init_en", RW0_en, 1);
      chk("init_wmode", RW0_wmode, 1);
      chk("init_addr", RW0_addr, i);
      chk("init_wdata", RW0_wdata, 0);
      chk("init_ready", bus.req_ready, 0);
      chk("init_done_low", init_done, 0);
    end
    @(negedge clock);
    chk("init_done", init_done, 1);
    chk("ready_after_init", bus.req_ready, 1);
    chk("en_after_init", RW0_en, 0);
    for (int i = 0; i < WORDS; i++) model_mem[i] = 8'h00;
    @(posedge clock);
    #1;
    running = 1;
  endtask

  task automatic do_req(input bit w, input int a, input logic [DW-1:0] d);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = AW'(a);
    bus.req_wdata = d;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.req_ready && n < 64);
    if (!bus.req_ready) chk("req_accept_timeout", bus.req_ready, 1);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic settle_rr(input int mode);
    rr_mode = mode;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    for (int i = 0; i < WORDS; i++) sram[i] = 8'h5A;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clock);
    reset_vals("rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    init_check();

    settle_rr(1);
    do_req(1, 8'h05, 8'hA5);
    do_req(0, 8'h05, 8'h00);
    @(negedge clock);
    chk("lat1_valid", bus.resp_valid, 0);
    @(negedge clock);
    chk("lat2_valid", bus.resp_valid, 1);
    chk("rd05_data", bus.resp_data, 8'hA5);
    wait_drain();
    do_req(0, 8'h06, 8'h00);
    wait_drain();
    chk("rd06_data", last_resp, 8'h00);

    settle_rr(0);
    do_req(0, 8'h05, 8'h00);
    do_req(0, 8'h06, 8'h00);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 7'h07;
    repeat (4) begin
      @(negedge clock);
      chk("held_ready", bus.req_ready, 0);
    end
    rr_mode = 1;
    do_req(0, 8'h07, 8'h00);
    wait_drain();
    chk("rd07_last", last_resp, 8'h00);

    settle_rr(0);
    do_req(0, 8'h01, 8'h00);
    do_req(0, 8'h02, 8'h00);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'h10;
    bus.req_wdata = 8'h3C;
    @(negedge clock);
    chk("wr_full_ready", bus.req_ready, 1);
    chk("wr_full_valid", bus.resp_valid, 1);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    rr_mode = 1;
    wait_drain();
    do_req(0, 8'h10, 8'h00);
    wait_drain();
    chk("rd10_data", last_resp, 8'h3C);

    base = resp_cnt;
    for (int i = 0; i < 8; i++) do_req(0, i, 8'h00);
    wait_drain();
    chk("stream_count", resp_cnt - base, 8);

    rr_mode = 2;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      do_req(1'($urandom_range(0, 1)), $urandom_range(0, 15),
             DW'($urandom));
    end
    settle_rr(1);
    wait_drain();

    settle_rr(0);
    do_req(1, 8'h40, 8'h77);
    do_req(0, 8'h40, 8'h00);
    do_req(0, 8'h40, 8'h00);
    reset   = 1'b1;
    running = 0;
    #1;
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_init_done", init_done, 0);
    rr_mode = 1;
    repeat (3) @(negedge clock);
    reset_vals("mid_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    init_check();
    repeat (3) begin
      @(negedge clock);
      chk("no_stale_valid", bus.resp_valid, 0);
    end
    do_req(0, 8'h40, 8'h00);
    wait_drain();
    chk("rd40_after_sweep", last_resp, 8'h00);

    chk("final_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
